uart_cmd_slave: RTL and testbench

Copter-side end of the wireless command link; it is the counterpart of the tester's CommMaster. It receives 3-byte UART frames (cmd, data[15:8], data[7:0]) and presents them as a parallel command to the flight-control command logic. It also serialises the single response byte (e.g. positive ack, battery level) back over TX. It sits between the RX/TX pins and the command-config block inside QuadCopter.

---
 rtl/comm_pkg.sv | 16 +
 rtl/uart_byte_rx.sv | 98 +++++++++
 rtl/uart_cmd_slave.sv | 172 +++++++++++++++++
 tb/tb_uart_cmd_slave.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// Shared types and constants for the copter-side command link.
// Frame format on the wire: cmd, data[15:8], data[7:0], each a standard 8N1 byte.
package comm_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {WAIT_CMD, WAIT_HI, WAIT_LO} frm_state_t;
  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

  localparam int   FRAME_BYTES = 3;
  localparam logic START_BIT   = 1'b0;
  localparam logic STOP_BIT    = 1'b1;

  localparam logic [7:0] BATT_CMD = 8'h01;
  localparam logic [7:0] POS_ACK  = 8'hA5;

endpackage

// File: rtl/uart_byte_rx.sv
// Single-byte UART receiver: RX synchroniser, start-bit qualification,
// mid-bit sampling of 8 data bits (LSB first) and stop-bit check.
module uart_byte_rx
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_byte_rdy,
  output logic       rx_err,
  output logic       rx_idle
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] HALF_M1 = BW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] FULL_M1 = BW'(BAUD_DIV - 1);

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          rdy_q, rdy_d;
  logic          err_q, err_d;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        baud_d = '0;
        if (rx_prev_q && !rx_sync_q) state_d = RX_START;
      end
      RX_START: begin
        // A line that is high again at mid start bit was only a glitch.
        if (baud_q == HALF_M1) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (baud_q == FULL_M1) begin
          baud_d  = '0;
          shreg_d = {rx_sync_q, shreg_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (baud_q == FULL_M1) begin
          baud_d  = '0;
          state_d = RX_IDLE;
          if (rx_sync_q == STOP_BIT) rdy_d = 1'b1;
          else                       err_d = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= RX_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
    end
  end

  assign rx_byte     = shreg_q;
  assign rx_byte_rdy = rdy_q;
  assign rx_err      = err_q;
  assign rx_idle     = (state_q == RX_IDLE);

endmodule

// File: rtl/uart_cmd_slave.sv
// Copter-side command link: assembles 3-byte RX frames into cmd/data with a
// sticky cmd_rdy, and serialises one response byte at a time on TX.
module uart_cmd_slave
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = 2604,
  parameter int TMO_BITS = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        snd_resp,
  output logic        tx_busy,
  output logic        resp_sent,
  output logic        frm_err
);

  localparam int BW        = $clog2(BAUD_DIV);
  localparam int TMO_LIMIT = TMO_BITS * BAUD_DIV;
  localparam int TW        = $clog2(TMO_LIMIT + 1);
  localparam logic [BW-1:0] FULL_M1 = BW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TMO_LIMIT);

  logic [7:0] rx_byte;
  logic       rx_byte_rdy, rx_err, rx_idle;

  uart_byte_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk         (clk),
    .rst         (rst),
    .rx          (RX),
    .rx_byte     (rx_byte),
    .rx_byte_rdy (rx_byte_rdy),
    .rx_err      (rx_err),
    .rx_idle     (rx_idle)
  );

  frm_state_t  frm_q, frm_d;
  logic [7:0]  shadow_cmd_q, shadow_cmd_d;
  logic [7:0]  shadow_hi_q, shadow_hi_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] data_q, data_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic [TW-1:0] idle_q, idle_d;
  logic        tmo_q, tmo_d;

  always_comb begin
    frm_d        = frm_q;
    shadow_cmd_d = shadow_cmd_q;
    shadow_hi_d  = shadow_hi_q;
    cmd_d        = cmd_q;
    data_d       = data_q;
    cmd_rdy_d    = clr_cmd_rdy ? 1'b0 : cmd_rdy_q;
    idle_d       = '0;
    tmo_d        = 1'b0;
    if (rx_err) begin
      frm_d = WAIT_CMD;
    end else if (rx_byte_rdy) begin
      case (frm_q)
        WAIT_CMD: begin
          shadow_cmd_d = rx_byte;
          cmd_rdy_d    = 1'b0;
          frm_d        = WAIT_HI;
        end
        WAIT_HI: begin
          shadow_hi_d = rx_byte;
          frm_d       = WAIT_LO;
        end
        WAIT_LO: begin
          // Completion is assigned last so it beats a same-cycle clear.
          cmd_d     = shadow_cmd_q;
          data_d    = {shadow_hi_q, rx_byte};
          cmd_rdy_d = 1'b1;
          frm_d     = WAIT_CMD;
        end
        default: frm_d = WAIT_CMD;
      endcase
    end else if (frm_q != WAIT_CMD && rx_idle) begin
      if (idle_q == TMO_MAX) begin
        tmo_d = 1'b1;
        frm_d = WAIT_CMD;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  tx_state_t     tx_state_q, tx_state_d;
  logic [9:0]    tx_shreg_q, tx_shreg_d;
  logic [BW-1:0] tx_baud_q, tx_baud_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic          resp_sent_q, resp_sent_d;

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_shreg_d  = tx_shreg_q;
    tx_baud_d   = tx_baud_q;
    tx_bit_d    = tx_bit_q;
    resp_sent_d = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (snd_resp) begin
          tx_state_d = TX_SHIFT;
          tx_shreg_d = {STOP_BIT, resp, START_BIT};
          tx_baud_d  = '0;
          tx_bit_d   = '0;
        end
      end
      TX_SHIFT: begin
        tx_baud_d = tx_baud_q + 1'b1;
        if (tx_baud_q == FULL_M1) begin
          // Ones shift in from the top so the line rests high when done.
          tx_baud_d  = '0;
          tx_shreg_d = {1'b1, tx_shreg_q[9:1]};
          if (tx_bit_q == 4'd9) begin
            tx_state_d  = TX_IDLE;
            resp_sent_d = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_q        <= WAIT_CMD;
      shadow_cmd_q <= '0;
      shadow_hi_q  <= '0;
      cmd_q        <= '0;
      data_q       <= '0;
      cmd_rdy_q    <= 1'b0;
      idle_q       <= '0;
      tmo_q        <= 1'b0;
      tx_state_q   <= TX_IDLE;
      tx_shreg_q   <= '1;
      tx_baud_q    <= '0;
      tx_bit_q     <= '0;
      resp_sent_q  <= 1'b0;
    end else begin
      frm_q        <= frm_d;
      shadow_cmd_q <= shadow_cmd_d;
      shadow_hi_q  <= shadow_hi_d;
      cmd_q        <= cmd_d;
      data_q       <= data_d;
      cmd_rdy_q    <= cmd_rdy_d;
      idle_q       <= idle_d;
      tmo_q        <= tmo_d;
      tx_state_q   <= tx_state_d;
      tx_shreg_q   <= tx_shreg_d;
      tx_baud_q    <= tx_baud_d;
      tx_bit_q     <= tx_bit_d;
      resp_sent_q  <= resp_sent_d;
    end
  end

  assign TX        = tx_shreg_q[0];
  assign cmd       = cmd_q;
  assign data      = data_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign tx_busy   = (tx_state_q == TX_SHIFT);
  assign resp_sent = resp_sent_q;
  assign frm_err   = rx_err | tmo_q;

endmodule

// File: tb/tb_uart_cmd_slave.sv
// Directed bench for uart_cmd_slave at 16 clocks per bit.
module tb_uart_cmd_slave;

  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX = 1'b1;
  logic        TX;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        snd_resp = 1'b0;
  logic        tx_busy, resp_sent, frm_err;

  always #5 clk = ~clk;

  uart_cmd_slave #(.BAUD_DIV(BD), .TMO_BITS(40)) dut (
    .clk         (clk),
    .rst         (rst),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .data        (data),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .snd_resp    (snd_resp),
    .tx_busy     (tx_busy),
    .resp_sent   (resp_sent),
    .frm_err     (frm_err)
  );

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   byte_start_cyc = 0;
  int   rdy_rise_cyc = -1;
  int   frm_err_cnt = 0;
  int   resp_sent_cnt = 0;
  logic cmd_rdy_last = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cmd_rdy && !cmd_rdy_last) rdy_rise_cyc = cyc;
    cmd_rdy_last = cmd_rdy;
    if (frm_err) frm_err_cnt++;
    if (resp_sent) resp_sent_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    byte_start_cyc = cyc;
    RX = 1'b0;
    tick(BD);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(BD);
    end
    RX = stop;
    tick(BD);
    RX = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l);
    send_byte(c, 1'b1);
    send_byte(h, 1'b1);
    send_byte(l, 1'b1);
    $display("frame sent: %02h %02h %02h -> cmd=%02h data=%04h cmd_rdy=%0b", c, h, l, cmd, data, cmd_rdy);
  endtask

  logic [9:0] exp_tx;
  int         err_base, sent_base;

  initial begin
    // Reset values
    tick(4);
    check_val("rst_TX", 32'(TX), 32'h1);
    check_val("rst_cmd", 32'(cmd), 32'h0);
    check_val("rst_data", 32'(data), 32'h0);
    check_val("rst_cmd_rdy", 32'(cmd_rdy), 32'h0);
    check_val("rst_tx_busy", 32'(tx_busy), 32'h0);
    check_val("rst_resp_sent", 32'(resp_sent), 32'h0);
    check_val("rst_frm_err", 32'(frm_err), 32'h0);
    rst = 1'b0;
    tick(5);

    // 1: frame assembly and latency (2 sync + 1 detect + 8 + 128 + 16 + 1 frame)
    rdy_rise_cyc = -1;
    send_frame(8'h01, 8'h12, 8'h34);
    check_val("t1_latency", 32'(rdy_rise_cyc - byte_start_cyc), 32'd156);
    check_val("t1_cmd", 32'(cmd), 32'h01);
    check_val("t1_data", 32'(data), 32'h1234);
    check_val("t1_cmd_rdy", 32'(cmd_rdy), 32'h1);
    tick(30);
    check_val("t1_cmd_rdy_hold", 32'(cmd_rdy), 32'h1);

    // 2: new frame over a held cmd_rdy, clear collides with completion
    send_byte(8'h02, 1'b1);
    check_val("t2_rdy_drop", 32'(cmd_rdy), 32'h0);
    check_val("t2_cmd_keep", 32'(cmd), 32'h01);
    check_val("t2_data_keep", 32'(data), 32'h1234);
    send_byte(8'hAB, 1'b1);
    check_val("t2_cmd_keep2", 32'(cmd), 32'h01);
    check_val("t2_data_keep2", 32'(data), 32'h1234);
    rdy_rise_cyc = -1;
    fork
      send_byte(8'hCD, 1'b1);
      begin
        tick(155);
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
      end
    join
    $display("frame sent: 02 ab cd with clear in completion cycle -> cmd=%02h data=%04h", cmd, data);
    check_val("t2_latency", 32'(rdy_rise_cyc - byte_start_cyc), 32'd156);
    check_val("t2_cmd_rdy_set_wins", 32'(cmd_rdy), 32'h1);
    check_val("t2_cmd", 32'(cmd), 32'h02);
    check_val("t2_data", 32'(data), 32'hABCD);
    clr_cmd_rdy = 1'b1;
    tick(1);
    clr_cmd_rdy = 1'b0;
    check_val("t2_clr", 32'(cmd_rdy), 32'h0);

    // 3: inter-byte timeout after two bytes
    err_base = frm_err_cnt;
    send_byte(8'h05, 1'b1);
    send_byte(8'h77, 1'b1);
    tick(600);
    check_val("t3_no_early_tmo", 32'(frm_err_cnt - err_base), 32'd0);
    tick(56);
    $display("timeout: partial frame 05 77 then 41 idle bit-times");
    check_val("t3_tmo_once", 32'(frm_err_cnt - err_base), 32'd1);
    check_val("t3_cmd_keep", 32'(cmd), 32'h02);
    check_val("t3_data_keep", 32'(data), 32'hABCD);
    send_frame(8'h06, 8'h00, 8'h01);
    check_val("t3_cmd", 32'(cmd), 32'h06);
    check_val("t3_data", 32'(data), 32'h0001);
    check_val("t3_cmd_rdy", 32'(cmd_rdy), 32'h1);

    // 4: bad stop bit, then a 3-clock glitch
    err_base = frm_err_cnt;
    send_byte(8'h01, 1'b0);
    tick(2);
    $display("bad stop: byte 01 with stop bit 0");
    check_val("t4_stop_err", 32'(frm_err_cnt - err_base), 32'd1);
    check_val("t4_cmd_rdy_keep", 32'(cmd_rdy), 32'h1);
    check_val("t4_cmd_keep", 32'(cmd), 32'h06);
    RX = 1'b0;
    tick(3);
    RX = 1'b1;
    tick(40);
    $display("glitch: 3-clock low pulse on RX");
    check_val("t4_glitch_no_err", 32'(frm_err_cnt - err_base), 32'd1);
    check_val("t4_glitch_rdy_keep", 32'(cmd_rdy), 32'h1);
    send_frame(8'h03, 8'h11, 8'h22);
    check_val("t4_cmd", 32'(cmd), 32'h03);
    check_val("t4_data", 32'(data), 32'h1122);

    // 5: response byte C0, late snd_resp ignored, back-to-back accepted
    exp_tx = 10'b1110000000;
    sent_base = resp_sent_cnt;
    resp = 8'hC0;
    snd_resp = 1'b1;
    tick(1);
    snd_resp = 1'b0;
    check_val("t5_busy", 32'(tx_busy), 32'h1);
    for (int c = 0; c < 160; c++) begin
      if (c % 16 == 8) check_val($sformatf("t5_tx_bit%0d", c / 16), 32'(TX), 32'(exp_tx[c / 16]));
      if (c == 50) begin
        resp = 8'hFF;
        snd_resp = 1'b1;
      end
      if (c == 51) snd_resp = 1'b0;
      if (c == 159) begin
        check_val("t5_busy_last", 32'(tx_busy), 32'h1);
        check_val("t5_no_early_sent", 32'(resp_sent), 32'h0);
      end
      tick(1);
    end
    $display("response sent: C0");
    check_val("t5_resp_sent", 32'(resp_sent), 32'h1);
    check_val("t5_busy_drop", 32'(tx_busy), 32'h0);
    resp = 8'hA5;
    snd_resp = 1'b1;
    tick(1);
    snd_resp = 1'b0;
    check_val("t5_b2b_busy", 32'(tx_busy), 32'h1);
    check_val("t5_b2b_start", 32'(TX), 32'h0);
    tick(170);
    $display("response sent: A5 back-to-back");
    check_val("t5_sent_count", 32'(resp_sent_cnt - sent_base), 32'd2);

    // 6: asynchronous reset during byte 2 and during a response
    send_byte(8'h01, 1'b1);
    resp = 8'h00;
    snd_resp = 1'b1;
    tick(1);
    snd_resp = 1'b0;
    RX = 1'b0;
    tick(40);
    check_val("t6_tx_low", 32'(TX), 32'h0);
    rst = 1'b1;
    RX = 1'b1;
    #1;
    check_val("t6_rst_TX", 32'(TX), 32'h1);
    check_val("t6_rst_cmd", 32'(cmd), 32'h0);
    check_val("t6_rst_data", 32'(data), 32'h0);
    check_val("t6_rst_cmd_rdy", 32'(cmd_rdy), 32'h0);
    check_val("t6_rst_tx_busy", 32'(tx_busy), 32'h0);
    tick(3);
    rst = 1'b0;
    tick(5);
    send_frame(8'h01, 8'h00, 8'h00);
    check_val("t6_cmd", 32'(cmd), 32'h01);
    check_val("t6_data", 32'(data), 32'h0000);
    check_val("t6_cmd_rdy", 32'(cmd_rdy), 32'h1);
    check_val("t6_TX_idle", 32'(TX), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
